// File: rtl/instr_seq_ctrl.sv
// ----------------------------------------------------------------------------
// instr_seq_ctrl
// Multi-cycle sequencer for the R/I-type datapath. Fetches one instruction
// from instruction memory over a req/valid handshake, then steps the decoder,
// ALU and register-file write enables through FETCH -> DECODE -> EXEC -> WB.
// Owns the PC and a saturating retired-instruction counter.
//
// Build option:
//   ILLEGAL_TRAP_EN  defined   : a non R/I opcode seen in DECODE halts the
//                                sequencer (pc and instr_cnt left unchanged).
//                    undefined : such opcodes run as a NOP (rf_we stays 0,
//                                pc advances, instr_cnt increments).
//
// Ports:
//   clk         in   1     clock, all logic on posedge
//   rst_n       in   1     synchronous active-low reset
//   run         in   1     1 = sequence instructions, 0 = park in IDLE after WB
//   imem_req    out  1     fetch request, held until imem_valid is sampled
//   imem_addr   out  PC_W  fetch address (= pc)
//   imem_valid  in   1     imem_data / imem_eof valid this cycle
//   imem_data   in   32    fetched instruction word
//   imem_eof    in   1     end of program, qualified by imem_valid
//   instr       out  32    latched instruction, stable DECODE..WB
//   dec_en      out  1     decoder enable (DECODE)
//   alu_en      out  1     ALU enable (EXEC)
//   rf_we       out  1     regfile write enable (WB, R/I-type with rd != 0)
//   pc          out  PC_W  current PC
//   instr_cnt   out  32    retired-instruction count, saturating
//   halted      out  1     sticky end-of-program flag
//   state       out  3     FSM state: IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 HALT=5
// ----------------------------------------------------------------------------
module instr_seq_ctrl #(
    parameter int              PC_W     = 32,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_data,
    input  logic            imem_eof,
    output logic [31:0]     instr,
    output logic            dec_en,
    output logic            alu_en,
    output logic            rf_we,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     instr_cnt,
    output logic            halted,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0]      OP_R    = 7'b0110011;
    localparam logic [6:0]      OP_I    = 7'b0010011;
    localparam logic [PC_W-1:0] PC_INC  = PC_W'(PC_STEP);
    localparam logic [31:0]     CNT_MAX = 32'hFFFF_FFFF;

    state_t cur_state;
    state_t nxt_state;
    logic   is_legal;
    logic   writes_rd;

    // Only R- and I-type are executed; anything else is a NOP or a trap.
    assign is_legal  = (instr[6:0] == OP_R) || (instr[6:0] == OP_I);
    assign writes_rd = is_legal && (instr[11:7] != 5'd0);

    assign state     = cur_state;
    assign imem_addr = pc;

    // Next-state logic.
    always_comb begin
        // NOTE: assign every always_comb output a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (run) nxt_state = S_FETCH;
            end
            S_FETCH: begin
                // End-of-program takes priority over any data on the same beat.
                if (imem_valid) nxt_state = imem_eof ? S_HALT : S_DECODE;
            end
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                nxt_state = is_legal ? S_EXEC : S_HALT;
`else
                nxt_state = S_EXEC;
`endif
            end
            S_EXEC: begin
                nxt_state = S_WB;
            end
            S_WB: begin
                nxt_state = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                nxt_state = S_HALT;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // State, datapath registers and registered outputs. The enables are
    // decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            cur_state <= S_IDLE;
            pc        <= RESET_PC;
            instr     <= '0;
            instr_cnt <= '0;
            imem_req  <= 1'b0;
            dec_en    <= 1'b0;
            alu_en    <= 1'b0;
            rf_we     <= 1'b0;
            halted    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            imem_req  <= (nxt_state == S_FETCH);
            dec_en    <= (nxt_state == S_DECODE);
            alu_en    <= (nxt_state == S_EXEC);
            rf_we     <= (nxt_state == S_WB) && writes_rd;
            // HALT is only left through reset, so this stays set.
            halted    <= (nxt_state == S_HALT);

            if ((cur_state == S_FETCH) && imem_valid && !imem_eof) begin
                instr <= imem_data;
            end

            // Retire on leaving WB: pc still points at this instruction
            // during WB and the next fetch uses the advanced value.
            if (cur_state == S_WB) begin
                pc <= pc + PC_INC;
                if (instr_cnt != CNT_MAX) begin
                    instr_cnt <= instr_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_instr_seq_ctrl
// Directed bench for instr_seq_ctrl. A transaction-level model tracks where
// the in-flight instruction is (cycles since its fetch was accepted) and
// checks every DUT output each cycle; literal checks at key points pin the
// model to hand-computed values. Inputs change 1 time unit after posedge,
// outputs are compared on the negedge.
// ----------------------------------------------------------------------------
module tb_instr_seq_ctrl;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        imem_eof;
    logic [31:0] instr;
    logic        dec_en;
    logic        alu_en;
    logic        rf_we;
    logic [31:0] pc;
    logic [31:0] instr_cnt;
    logic        halted;
    logic [2:0]  state;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    instr_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .imem_eof   (imem_eof),
        .instr      (instr),
        .dec_en     (dec_en),
        .alu_en     (alu_en),
        .rf_we      (rf_we),
        .pc         (pc),
        .instr_cnt  (instr_cnt),
        .halted     (halted),
        .state      (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_ri(input logic [31:0] w);
        return (w[6:0] == 7'b0110011) || (w[6:0] == 7'b0010011);
    endfunction

    // ------------------------------------------------------------------
    // Model: m_req = fetch outstanding, m_age = cycles since the fetch was
    // accepted (1 decode, 2 execute, 3 write-back, 0 none in flight).
    // ------------------------------------------------------------------
    bit          m_live = 1'b0;
    bit          m_req;
    int          m_age;
    bit          m_halt;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_instr;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live  <= 1'b1;
            m_req   <= 1'b0;
            m_age   <= 0;
            m_halt  <= 1'b0;
            m_pc    <= 32'd0;
            m_cnt   <= 32'd0;
            m_instr <= 32'd0;
        end else if (m_live && !m_halt) begin
            if (m_age == 0 && !m_req) begin
                m_req <= run;
            end else if (m_req) begin
                if (imem_valid) begin
                    m_req <= 1'b0;
                    if (imem_eof) m_halt <= 1'b1;
                    else begin
                        m_instr <= imem_data;
                        m_age   <= 1;
                    end
                end
            end else if (m_age == 1) begin
                if (TRAP && !is_ri(m_instr)) begin
                    m_halt <= 1'b1;
                    m_age  <= 0;
                end else m_age <= 2;
            end else if (m_age == 2) begin
                m_age <= 3;
            end else begin
                m_pc  <= m_pc + 32'd4;
                m_cnt <= (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
                m_age <= 0;
                m_req <= run;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            int es;
            es = m_halt ? 5 : (m_age != 0) ? m_age + 1 : m_req ? 1 : 0;
            check("m_state",     32'(state),     32'(es));
            check("m_imem_req",  32'(imem_req),  32'(m_req));
            check("m_imem_addr", imem_addr,      m_pc);
            check("m_pc",        pc,             m_pc);
            check("m_instr_cnt", instr_cnt,      m_cnt);
            check("m_halted",    32'(halted),    32'(m_halt));
            check("m_dec_en",    32'(dec_en),    32'(m_age == 1));
            check("m_alu_en",    32'(alu_en),    32'(m_age == 2));
            check("m_rf_we",     32'(rf_we),
                  32'(m_age == 3 && is_ri(m_instr) && m_instr[11:7] != 5'd0));
            if (m_age != 0) check("m_instr", instr, m_instr);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for imem_req, stall `delay` cycles, then answer for one beat.
    task automatic fetch(input logic [31:0] data, input logic eof, input int delay);
        int waited = 0;
        while (!imem_req && waited < 20) begin
            step(1);
            waited++;
        end
        check("fetch_req_seen", 32'(imem_req), 32'd1);
        step(delay);
        imem_valid = 1'b1;
        imem_data  = data;
        imem_eof   = eof;
        step(1);
        imem_valid = 1'b0;
        imem_eof   = 1'b0;
        imem_data  = 32'hDEAD_BEEF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 32'd0;
        imem_eof   = 1'b0;

        // Reset state.
        step(5);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_enables", 32'({dec_en, alu_en, rf_we, halted}), 32'd0);
        rst_n = 1'b1;
        run   = 1'b1;
        step(1);
        check("idle_to_fetch_req", 32'(imem_req), 32'd1);

        // addi x1,x0,5 answered immediately.
        fetch(32'h0050_0093, 1'b0, 0);
        check("addi_dec_en", 32'(dec_en), 32'd1);
        check("addi_instr", instr, 32'h0050_0093);
        step(1);
        check("addi_alu_en", 32'(alu_en), 32'd1);
        step(1);
        check("addi_rf_we", 32'(rf_we), 32'd1);
        step(1);
        check("addi_pc", pc, 32'd4);
        check("addi_cnt", instr_cnt, 32'd1);
        check("addi_next_req", 32'(imem_req), 32'd1);

        // R-type rd=0 with 3 wait cycles; a stray eof beat in DECODE is ignored.
        fetch(32'h0000_0033, 1'b0, 3);
        check("r0_decode", 32'(state), 32'd2);
        imem_valid = 1'b1;
        imem_eof   = 1'b1;
        step(1);
        imem_valid = 1'b0;
        imem_eof   = 1'b0;
        check("stray_valid_exec", 32'(state), 32'd3);
        step(1);
        check("r0_rf_we", 32'(rf_we), 32'd0);
        step(1);
        check("r0_pc", pc, 32'd8);

        // End of program after two instructions.
        fetch(32'h0000_0000, 1'b1, 1);
        check("eof_state", 32'(state), 32'd5);
        check("eof_halted", 32'(halted), 32'd1);
        check("eof_pc", pc, 32'd8);
        check("eof_cnt", instr_cnt, 32'd2);
        run = 1'b0;
        step(2);
        run = 1'b1;
        step(3);
        check("halt_no_req", 32'(imem_req), 32'd0);
        check("halt_sticky", 32'(state), 32'd5);

        // Reset out of HALT, then reset in the middle of a fetch.
        rst_n = 1'b0;
        step(1);
        check("rst2_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        step(1);
        check("rst2_fetch", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        step(1);
        check("midfetch_rst_req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Drop run mid-instruction: completes to WB then parks in IDLE.
        fetch(32'h00A0_0113, 1'b0, 2);
        run = 1'b0;
        step(2);
        check("park_rf_we", 32'(rf_we), 32'd1);
        step(1);
        check("park_idle", 32'(state), 32'd0);
        check("park_pc", pc, 32'd4);
        step(2);
        check("park_no_req", 32'(imem_req), 32'd0);
        run = 1'b1;
        step(1);

        // add x3,x1,x2 writes back; then an illegal opcode (lw).
        fetch(32'h0020_81B3, 1'b0, 0);
        step(2);
        check("add_rf_we", 32'(rf_we), 32'd1);
        step(1);
        check("add_pc", pc, 32'd8);
        fetch(32'h0000_2083, 1'b0, 0);
        check("ill_dec_en", 32'(dec_en), 32'd1);
        step(1);
        if (TRAP) begin
            check("ill_trap_state", 32'(state), 32'd5);
            check("ill_trap_halted", 32'(halted), 32'd1);
            step(2);
            check("ill_trap_pc", pc, 32'd8);
            check("ill_trap_cnt", instr_cnt, 32'd2);
        end else begin
            check("ill_nop_alu_en", 32'(alu_en), 32'd1);
            step(1);
            check("ill_nop_rf_we", 32'(rf_we), 32'd0);
            step(1);
            check("ill_nop_pc", pc, 32'd12);
            check("ill_nop_cnt", instr_cnt, 32'd3);
            step(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
